// File: rtl/dct_pkg.sv
// Shared DCT definitions: coefficient width, block dimension and the transpose
// bank-state encoding used by the row-DCT, transpose and column-DCT stages.
package dct_pkg;

    localparam int DCT_DATA_WIDTH = 32;
    localparam int DCT_N          = 8;
    localparam int DCT_IDX_W      = 3;

    typedef enum logic [1:0] {
        BANK_EMPTY    = 2'd0,
        BANK_FILLING  = 2'd1,
        BANK_FULL     = 2'd2,
        BANK_DRAINING = 2'd3
    } bank_state_t;

    function automatic logic bank_holds_block(input bank_state_t s);
        return (s == BANK_FULL) || (s == BANK_DRAINING);
    endfunction

    function automatic logic bank_writable(input bank_state_t s);
        return (s == BANK_EMPTY) || (s == BANK_FILLING);
    endfunction

endpackage

// File: rtl/dct_tp_bank.sv
// One 8x8 transpose bank: rows are written whole, columns are read
// combinationally. Contents carry no reset; bank state lives in the parent.
module dct_tp_bank
    import dct_pkg::*;
#(
    parameter int DATA_WIDTH = DCT_DATA_WIDTH
) (
    input  logic                          clk,
    input  logic                          wr_en,
    input  logic [DCT_IDX_W-1:0]          wr_row,
    input  logic [DCT_N*DATA_WIDTH-1:0]   wr_data,
    input  logic [DCT_IDX_W-1:0]          rd_col,
    output logic [DCT_N*DATA_WIDTH-1:0]   rd_data
);

    logic [DATA_WIDTH-1:0] mem_r [DCT_N][DCT_N];

    // Row write port: element c of the incoming row lands in column c.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int c = 0; c < DCT_N; c++) begin
                mem_r[wr_row][c] <= wr_data[c*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Column read port: element r of the selected column goes to lane r.
    always_comb begin
        rd_data = '0;
        for (int r = 0; r < DCT_N; r++) begin
            rd_data[r*DATA_WIDTH +: DATA_WIDTH] = mem_r[r][rd_col];
        end
    end

endmodule

// File: rtl/dct_transpose_8x8.sv
// Ping-pong 8x8 transpose between the row-DCT and column-DCT stages: rows
// fill one bank while the other drains column by column.
module dct_transpose_8x8
    import dct_pkg::*;
#(
    parameter int DATA_WIDTH = DCT_DATA_WIDTH
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DCT_N*DATA_WIDTH-1:0]   in_row,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DCT_N*DATA_WIDTH-1:0]   out_col,
    output logic                          out_last,
    output logic [1:0]                    blocks_held
);

    localparam logic [DCT_IDX_W-1:0] LAST_IDX = 3'd7;

    bank_state_t               state_r   [2];
    bank_state_t               state_n_s [2];
    logic                      wr_bank_r, wr_bank_n_s;
    logic                      rd_bank_r, rd_bank_n_s;
    logic [DCT_IDX_W-1:0]      wr_cnt_r, wr_cnt_n_s;
    logic [DCT_IDX_W-1:0]      rd_cnt_r, rd_cnt_n_s;
    logic                      in_ready_r, in_ready_n_s;
    logic                      out_valid_r, out_valid_n_s;
    logic                      out_last_r, out_last_n_s;
    logic [1:0]                blocks_held_r, blocks_held_n_s;
    logic                      in_xfer_s, out_xfer_s;
    logic [1:0]                bank_wr_en_s;
    logic [DCT_N*DATA_WIDTH-1:0] bank_rd_data_s [2];
    logic [DCT_N*DATA_WIDTH-1:0] out_col_s;

    assign in_xfer_s  = in_valid && in_ready_r;
    assign out_xfer_s = out_valid_r && out_ready;

    assign bank_wr_en_s[0] = in_xfer_s && (wr_bank_r == 1'b0);
    assign bank_wr_en_s[1] = in_xfer_s && (wr_bank_r == 1'b1);

    dct_tp_bank #(.DATA_WIDTH(DATA_WIDTH)) u_bank0 (
        .clk     (clk),
        .wr_en   (bank_wr_en_s[0]),
        .wr_row  (wr_cnt_r),
        .wr_data (in_row),
        .rd_col  (rd_cnt_r),
        .rd_data (bank_rd_data_s[0])
    );

    dct_tp_bank #(.DATA_WIDTH(DATA_WIDTH)) u_bank1 (
        .clk     (clk),
        .wr_en   (bank_wr_en_s[1]),
        .wr_row  (wr_cnt_r),
        .wr_data (in_row),
        .rd_col  (rd_cnt_r),
        .rd_data (bank_rd_data_s[1])
    );

    // Next-state for both banks; write and read always target different banks.
    always_comb begin
        state_n_s[0] = state_r[0];
        state_n_s[1] = state_r[1];
        wr_bank_n_s  = wr_bank_r;
        rd_bank_n_s  = rd_bank_r;
        wr_cnt_n_s   = wr_cnt_r;
        rd_cnt_n_s   = rd_cnt_r;

        if (in_xfer_s) begin
            if (wr_cnt_r == LAST_IDX) begin
                state_n_s[wr_bank_r] = BANK_FULL;
                wr_cnt_n_s           = 3'd0;
                wr_bank_n_s          = ~wr_bank_r;
            end else begin
                state_n_s[wr_bank_r] = BANK_FILLING;
                wr_cnt_n_s           = wr_cnt_r + 3'd1;
            end
        end else begin
            wr_cnt_n_s = wr_cnt_r;
        end

        if (out_xfer_s) begin
            if (rd_cnt_r == LAST_IDX) begin
                state_n_s[rd_bank_r] = BANK_EMPTY;
                rd_cnt_n_s           = 3'd0;
                rd_bank_n_s          = ~rd_bank_r;
            end else begin
                state_n_s[rd_bank_r] = BANK_DRAINING;
                rd_cnt_n_s           = rd_cnt_r + 3'd1;
            end
        end else begin
            rd_cnt_n_s = rd_cnt_r;
        end

        in_ready_n_s    = bank_writable(state_n_s[wr_bank_n_s]);
        out_valid_n_s   = bank_holds_block(state_n_s[rd_bank_n_s]);
        out_last_n_s    = out_valid_n_s && (rd_cnt_n_s == LAST_IDX);
        blocks_held_n_s = {1'b0, bank_holds_block(state_n_s[0])}
                        + {1'b0, bank_holds_block(state_n_s[1])};
    end

    // Status flags are registered from the next state so they track it exactly.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r[0]    <= BANK_EMPTY;
            state_r[1]    <= BANK_EMPTY;
            wr_bank_r     <= 1'b0;
            rd_bank_r     <= 1'b0;
            wr_cnt_r      <= 3'd0;
            rd_cnt_r      <= 3'd0;
            in_ready_r    <= 1'b1;
            out_valid_r   <= 1'b0;
            out_last_r    <= 1'b0;
            blocks_held_r <= 2'd0;
        end else begin
            state_r[0]    <= state_n_s[0];
            state_r[1]    <= state_n_s[1];
            wr_bank_r     <= wr_bank_n_s;
            rd_bank_r     <= rd_bank_n_s;
            wr_cnt_r      <= wr_cnt_n_s;
            rd_cnt_r      <= rd_cnt_n_s;
            in_ready_r    <= in_ready_n_s;
            out_valid_r   <= out_valid_n_s;
            out_last_r    <= out_last_n_s;
            blocks_held_r <= blocks_held_n_s;
        end
    end

    // Column mux from the read bank, forced to zero when nothing is presented.
    always_comb begin
        if (!out_valid_r) begin
            out_col_s = '0;
        end else if (rd_bank_r) begin
            out_col_s = bank_rd_data_s[1];
        end else begin
            out_col_s = bank_rd_data_s[0];
        end
    end

    assign in_ready    = in_ready_r;
    assign out_valid   = out_valid_r;
    assign out_last    = out_last_r;
    assign blocks_held = blocks_held_r;
    assign out_col     = out_col_s;

endmodule
